// File: rtl/switch_sched_pkg.sv
// Shared types, width helpers and reset constants for the switch sequencer.
package switch_sched_pkg;

  localparam int unsigned DEF_CHANNELS = 4;
  localparam int unsigned DEF_DEPTH    = 8;
  localparam int unsigned DEF_TIME_W   = 24;
  localparam int unsigned DEF_TRANS_W  = 8;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    TRANS     = 2'd1,
    EXHAUSTED = 2'd2
  } chan_state_e;

  localparam chan_state_e RST_STATE   = HOLD;
  localparam logic        RST_RUNNING = 1'b0;
  localparam logic        RST_DONE    = 1'b0;
  localparam logic        RST_SW      = 1'b0;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Table index width.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Length / pointer width: must hold 0..DEPTH inclusive.
  function automatic int unsigned len_w(input int unsigned depth);
    return idx_w(depth) + 1;
  endfunction

endpackage

// File: rtl/switch_sched_chan.sv
// One switch channel: toggle-time table, pointer, break-before-make FSM.
module switch_sched_chan
  import switch_sched_pkg::*;
#(
  parameter  int unsigned DEPTH   = DEF_DEPTH,
  parameter  int unsigned TIME_W  = DEF_TIME_W,
  parameter  int unsigned TRANS_W = DEF_TRANS_W,
  localparam int unsigned IDX_W   = idx_w(DEPTH),
  localparam int unsigned LEN_W   = len_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               tick,
  input  logic               wrap,
  input  logic               init,
  input  logic [TRANS_W-1:0] trans_len,
  input  logic [TIME_W-1:0]  now,
  input  logic               tbl_we,
  input  logic [IDX_W-1:0]   tbl_idx,
  input  logic [TIME_W-1:0]  tbl_time,
  input  logic               len_we,
  input  logic [LEN_W-1:0]   len,
  output logic               sw_on,
  output logic               sw_trans,
  output logic               exhausted_c
);

  chan_state_e        state_q, state_d;
  logic               level_q, level_d;
  logic [LEN_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_q;
  logic [TRANS_W-1:0] cnt_q, cnt_d;
  logic [TIME_W-1:0]  tbl_q [DEPTH];
  logic               armed_c;
  logic               last_c;

  // Toggle-time table; contents survive reset.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[tbl_idx] <= tbl_time;
  end

  // Valid-entry count, clamped to the table depth.
  always_ff @(posedge clk) begin
    if (rst)         len_q <= '0;
    else if (len_we) len_q <= (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  end

  // Next entry is due (late or unsorted entries fire immediately).
  assign armed_c     = (ptr_q < len_q) && (tbl_q[ptr_q[IDX_W-1:0]] <= now);
  assign last_c      = (ptr_q + LEN_W'(1)) >= len_q;
  assign exhausted_c = (state_q == EXHAUSTED);

  // State register plus registered switch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      level_q  <= RST_SW;
      ptr_q    <= '0;
      cnt_q    <= '0;
      sw_on    <= RST_SW;
      sw_trans <= RST_SW;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      sw_on    <= level_d & (state_d != TRANS);
      sw_trans <= (state_d == TRANS);
    end
  end

  // Next-state: start/stop override, then per-tick schedule, then period wrap.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = (len_q == '0) ? EXHAUSTED : HOLD;
      level_d = init;
      ptr_d   = '0;
      cnt_d   = '0;
    end else if (stop) begin
      // Abort restores the pre-transition level, pointer untouched.
      if (state_q == TRANS) state_d = HOLD;
      cnt_d = '0;
    end else if (tick) begin
      case (state_q)
        HOLD: begin
          if (armed_c) begin
            if (trans_len == '0) begin
              level_d = ~level_q;
              ptr_d   = ptr_q + LEN_W'(1);
              state_d = last_c ? EXHAUSTED : HOLD;
            end else begin
              state_d = TRANS;
              cnt_d   = trans_len;
            end
          end else if (ptr_q >= len_q) begin
            state_d = EXHAUSTED;
          end
        end
        TRANS: begin
          if (cnt_q <= TRANS_W'(1)) begin
            level_d = ~level_q;
            ptr_d   = ptr_q + LEN_W'(1);
            cnt_d   = '0;
            state_d = last_c ? EXHAUSTED : HOLD;
          end else begin
            cnt_d = cnt_q - TRANS_W'(1);
          end
        end
        default: ;
      endcase
      // Period wrap re-arms the table; level and transitions carry over.
      if (wrap) begin
        ptr_d = '0;
        if ((state_d == EXHAUSTED) && (len_q != '0)) state_d = HOLD;
      end
    end
  end

endmodule

// File: rtl/switch_sched.sv
// Multi-channel timed switch sequencer: time base, period wrap, run control.
module switch_sched
  import switch_sched_pkg::*;
#(
  parameter  int unsigned CHANNELS = DEF_CHANNELS,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned TIME_W   = DEF_TIME_W,
  parameter  int unsigned TRANS_W  = DEF_TRANS_W,
  localparam int unsigned CH_W     = ch_w(CHANNELS),
  localparam int unsigned IDX_W    = idx_w(DEPTH),
  localparam int unsigned LEN_W    = len_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                start,
  input  logic                stop,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [TIME_W-1:0]   cfg_time,
  input  logic                cfg_len_we,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [CHANNELS-1:0] cfg_init,
  input  logic [TIME_W-1:0]   cfg_period,
  input  logic [TRANS_W-1:0]  cfg_trans,
  output logic                running,
  output logic                done,
  output logic [TIME_W-1:0]   now,
  output logic [CHANNELS-1:0] sw_on,
  output logic [CHANNELS-1:0] sw_trans
);

  logic [TIME_W-1:0]   period_q;
  logic [TRANS_W-1:0]  trans_q;
  logic [CHANNELS-1:0] exh_c;
  logic                stop_c;
  logic                finish_c;
  logic                adv_c;
  logic                wrap_c;

  // Start outranks stop; stop outranks tick and completion.
  assign stop_c   = stop & running & ~start;
  assign finish_c = running & ~start & ~stop & (period_q == '0) & (&exh_c) & ~(|sw_trans);
  assign adv_c    = tick & running & ~start & ~stop & ~finish_c;
  assign wrap_c   = adv_c & (period_q != '0) & (now == (period_q - TIME_W'(1)));

  // Run control, time base and start-sampled configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= RST_RUNNING;
      done     <= RST_DONE;
      now      <= '0;
      period_q <= '0;
      trans_q  <= '0;
    end else if (start) begin
      running  <= 1'b1;
      done     <= 1'b0;
      now      <= '0;
      period_q <= cfg_period;
      trans_q  <= cfg_trans;
    end else if (stop_c) begin
      running <= 1'b0;
    end else if (finish_c) begin
      running <= 1'b0;
      done    <= 1'b1;
    end else if (adv_c) begin
      now <= wrap_c ? '0 : now + TIME_W'(1);
    end
  end

  // One channel instance per switch; config writes only while idle.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic sel_c;
    assign sel_c = (cfg_ch == CH_W'(i)) & ~running;

    switch_sched_chan #(
      .DEPTH   (DEPTH),
      .TIME_W  (TIME_W),
      .TRANS_W (TRANS_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop_c),
      .tick        (adv_c),
      .wrap        (wrap_c),
      .init        (cfg_init[i]),
      .trans_len   (trans_q),
      .now         (now),
      .tbl_we      (cfg_we & sel_c),
      .tbl_idx     (cfg_idx),
      .tbl_time    (cfg_time),
      .len_we      (cfg_len_we & sel_c),
      .len         (cfg_len),
      .sw_on       (sw_on[i]),
      .sw_trans    (sw_trans[i]),
      .exhausted_c (exh_c[i])
    );
  end

endmodule
